// File: rtl/axi_mem_responder_if.sv
// AXI4 bundle between a bus master and the on-chip memory responder.
// The slave modport is the responder's view; the master modport is the initiator's.
interface axi_mem_responder_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backing the BASE_ADDR window with an on-chip word array.
// One transaction at a time; simultaneous AW/AR requests are granted alternately.
module axi_mem_responder #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 64,
  parameter int                ID_W      = 4,
  parameter int                MEM_BYTES = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_mem_responder_if.slave   s_axi
);

  localparam int OFF_W = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WRESP = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] sz,
                                                    input logic [1:0] bt,
                                                    input logic [7:0] ln);
    logic [ADDR_W-1:0] step;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] nxt;
    step = ADDR_W'(1) << sz;
    mask = ((ADDR_W'(ln) + ADDR_W'(1)) << sz) - ADDR_W'(1);
    case (bt)
      2'b00:   nxt = a;
      2'b10:   nxt = (a & ~mask) | ((a + step) & mask);
      default: nxt = a + step;
    endcase
    return nxt;
  endfunction

  function automatic logic f_in_win(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W];
  endfunction

  function automatic logic f_burst_bad(input logic [2:0] sz, input logic [1:0] bt,
                                       input logic [7:0] ln);
    logic wrap_len_ok;
    wrap_len_ok = (ln == 8'd1) || (ln == 8'd3) || (ln == 8'd7) || (ln == 8'd15);
    return (sz > 3'd3) || (bt == 2'b11) || ((bt == 2'b10) && !wrap_len_ok);
  endfunction

  // Response codes are ordered so the numerically larger one is the worse one.
  function automatic logic [1:0] f_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_W-1:0]   r_mem [0:WORDS-1];

  state_t              r_state;
  logic                r_prio_rd;
  logic [ID_W-1:0]     r_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic                r_bad;
  logic [7:0]          r_cnt;
  logic [1:0]          r_worst;

  logic                r_awready;
  logic                r_arready;
  logic                r_wready;
  logic                r_bvalid;
  logic [ID_W-1:0]     r_bid;
  logic [1:0]          r_bresp;
  logic                r_rvalid;
  logic [ID_W-1:0]     r_rid;
  logic [DATA_W-1:0]   r_rdata;
  logic [1:0]          r_rresp;
  logic                r_rlast;

  logic                w_in_win;
  logic                w_mem_ok;
  logic [OFF_W-4:0]    w_widx;
  logic [1:0]          w_beat_resp;
  logic                w_w_hs;
  logic                w_cnt_last;
  logic [1:0]          w_wbeat_resp;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_unused_sidebands;

  assign w_in_win    = f_in_win(r_addr);
  assign w_mem_ok    = w_in_win && (r_size <= 3'd3);
  assign w_widx      = r_addr[OFF_W-1:3];
  assign w_w_hs      = r_wready && s_axi.wvalid;
  assign w_cnt_last  = (r_cnt == r_len);
  assign w_next_addr = f_next_addr(r_addr, r_size, r_burst, r_len);
  assign w_mem_we    = !reset && (r_state == S_WDATA) && w_w_hs && w_mem_ok;

  assign w_unused_sidebands = ^{s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                                s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos};

  // Per-beat response: out-of-window dominates, then burst-level or wlast protocol errors.
  always_comb begin
    w_beat_resp  = 2'b00;
    w_wbeat_resp = 2'b00;
    if (!w_in_win) begin
      w_beat_resp = 2'b11;
    end else if (r_bad) begin
      w_beat_resp = 2'b10;
    end else begin
      w_beat_resp = 2'b00;
    end
    if (s_axi.wlast != w_cnt_last) begin
      w_wbeat_resp = f_worst(w_beat_resp, 2'b10);
    end else begin
      w_wbeat_resp = w_beat_resp;
    end
  end

  // Byte-enabled word write; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (s_axi.wstrb[b]) begin
          r_mem[w_widx][8*b +: 8] <= s_axi.wdata[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_prio_rd <= 1'b0;
      r_id      <= {ID_W{1'b0}};
      r_addr    <= {ADDR_W{1'b0}};
      r_len     <= 8'd0;
      r_size    <= 3'd0;
      r_burst   <= 2'b00;
      r_bad     <= 1'b0;
      r_cnt     <= 8'd0;
      r_worst   <= 2'b00;
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= {ID_W{1'b0}};
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rid     <= {ID_W{1'b0}};
      r_rdata   <= {DATA_W{1'b0}};
      r_rresp   <= 2'b00;
      r_rlast   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_awready) begin
            r_awready <= 1'b0;
            if (s_axi.awvalid) begin
              r_id      <= s_axi.awid;
              r_addr    <= s_axi.awaddr;
              r_len     <= s_axi.awlen;
              r_size    <= s_axi.awsize;
              r_burst   <= s_axi.awburst;
              r_bad     <= f_burst_bad(s_axi.awsize, s_axi.awburst, s_axi.awlen);
              r_cnt     <= 8'd0;
              r_worst   <= 2'b00;
              r_prio_rd <= 1'b1;
              r_wready  <= 1'b1;
              r_state   <= S_WDATA;
            end
          end else if (r_arready) begin
            r_arready <= 1'b0;
            if (s_axi.arvalid) begin
              r_id      <= s_axi.arid;
              r_addr    <= s_axi.araddr;
              r_len     <= s_axi.arlen;
              r_size    <= s_axi.arsize;
              r_burst   <= s_axi.arburst;
              r_bad     <= f_burst_bad(s_axi.arsize, s_axi.arburst, s_axi.arlen);
              r_cnt     <= 8'd0;
              r_prio_rd <= 1'b0;
              r_state   <= S_RDATA;
            end
          end else if (s_axi.awvalid && (!s_axi.arvalid || !r_prio_rd)) begin
            r_awready <= 1'b1;
          end else if (s_axi.arvalid) begin
            r_arready <= 1'b1;
          end
        end
        S_WDATA: begin
          if (w_w_hs) begin
            r_worst <= f_worst(r_worst, w_wbeat_resp);
            if (s_axi.wlast || w_cnt_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= f_worst(r_worst, w_wbeat_resp);
              r_state  <= S_WRESP;
            end else begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        S_WRESP: begin
          if (s_axi.bready) begin
            r_bvalid <= 1'b0;
            r_state  <= S_IDLE;
          end
        end
        S_RDATA: begin
          // A beat is loaded while rvalid is low, giving one bubble between beats.
          if (!r_rvalid) begin
            r_rvalid <= 1'b1;
            r_rid    <= r_id;
            r_rdata  <= w_mem_ok ? r_mem[w_widx] : {DATA_W{1'b0}};
            r_rresp  <= w_beat_resp;
            r_rlast  <= w_cnt_last;
          end else if (s_axi.rready) begin
            r_rvalid <= 1'b0;
            if (r_rlast) begin
              r_rlast <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_addr <= w_next_addr;
              r_cnt  <= r_cnt + 8'd1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_axi.awready = r_awready;
  assign s_axi.arready = r_arready;
  assign s_axi.wready  = r_wready;
  assign s_axi.bvalid  = r_bvalid;
  assign s_axi.bid     = r_bid;
  assign s_axi.bresp   = r_bresp;
  assign s_axi.rvalid  = r_rvalid;
  assign s_axi.rid     = r_rid;
  assign s_axi.rdata   = r_rdata;
  assign s_axi.rresp   = r_rresp;
  assign s_axi.rlast   = r_rlast;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: stimulus tasks push expected B/R responses
// into queues; a negedge monitor pops and compares on every B/R handshake.
module tb_axi_mem_responder;

  logic clk;
  logic reset;

  axi_mem_responder_if #(.ID_W(4), .ADDR_W(32), .DATA_W(64)) s_axi ();

  axi_mem_responder #(
    .ADDR_W(32), .DATA_W(64), .ID_W(4), .MEM_BYTES(4096), .BASE_ADDR(32'h8000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s_axi (s_axi)
  );

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  b_exp_t      exp_b[$];
  r_exp_t      exp_r[$];
  int          n_checks;
  int          n_fail;
  string       grant_log;
  logic [63:0] tb_wd [16];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic note_fail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected handshake", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares whatever the DUT presents at a B/R handshake.
  always @(negedge clk) begin
    b_exp_t eb;
    r_exp_t er;
    if (!reset) begin
      if (s_axi.bvalid && s_axi.bready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected", 64'd1, 64'd0);
        end else begin
          eb = exp_b.pop_front();
          check("bid", s_axi.bid, eb.id);
          check("bresp", s_axi.bresp, eb.resp);
        end
      end
      if (s_axi.rvalid && s_axi.rready) begin
        if (exp_r.size() == 0) begin
          check("r_unexpected", 64'd1, 64'd0);
        end else begin
          er = exp_r.pop_front();
          check("rid", s_axi.rid, er.id);
          check("rdata", s_axi.rdata, er.data);
          check("rresp", s_axi.rresp, er.resp);
          check("rlast", s_axi.rlast, er.last);
        end
      end
    end
  end

  task automatic push_r(input logic [3:0] id, input logic [63:0] d, input logic [1:0] resp,
                        input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len;
    s_axi.awsize = size; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
    t = 0;
    while (!s_axi.awready && t < 60) begin tick(); t++; end
    if (!s_axi.awready) begin
      note_fail("aw_handshake");
    end else begin
      tick();
      grant_log = {grant_log, "W"};
    end
    s_axi.awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int t;
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len;
    s_axi.arsize = size; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
    t = 0;
    while (!s_axi.arready && t < 60) begin tick(); t++; end
    if (!s_axi.arready) begin
      note_fail("ar_handshake");
    end else begin
      tick();
      grant_log = {grant_log, "R"};
    end
    s_axi.arvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb,
                             input int nbeats, input logic [1:0] exp_resp, input int bready_hold);
    b_exp_t e;
    int t;
    e.id = id; e.resp = exp_resp;
    exp_b.push_back(e);
    do_aw(id, addr, len, size, burst);
    for (int k = 0; k < nbeats; k++) begin
      s_axi.wdata = tb_wd[k]; s_axi.wstrb = strb;
      s_axi.wlast = (k == nbeats - 1); s_axi.wvalid = 1'b1;
      t = 0;
      while (!s_axi.wready && t < 60) begin tick(); t++; end
      if (!s_axi.wready) begin
        note_fail("w_handshake");
        break;
      end
      tick();
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0;
    if (bready_hold > 0) begin
      s_axi.bready = 1'b0;
      t = 0;
      while (!s_axi.bvalid && t < 60) begin tick(); t++; end
      for (int h = 0; h < bready_hold; h++) begin
        check("bvalid_held", s_axi.bvalid, 1'b1);
        check("bresp_held", s_axi.bresp, exp_resp);
        tick();
      end
      s_axi.bready = 1'b1;
    end
    t = 0;
    while (!s_axi.bvalid && t < 60) begin tick(); t++; end
    if (!s_axi.bvalid) note_fail("b_handshake");
    else tick();
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int stall_at);
    int     n;
    int     t;
    int     w;
    logic   done;
    r_exp_t e;
    do_ar(id, addr, len, size, burst);
    s_axi.rready = 1'b1;
    n = 0; t = 0; done = 1'b0;
    while (!done && t < 300) begin
      if (s_axi.rvalid && s_axi.rready) begin
        n++;
        done = s_axi.rlast;
        tick();
        if (n == stall_at && !done) begin
          s_axi.rready = 1'b0;
          w = 0;
          while (!s_axi.rvalid && w < 20) begin tick(); w++; end
          e = (exp_r.size() > 0) ? exp_r[0] : '0;
          for (int h = 0; h < 5; h++) begin
            check("stall_rvalid", s_axi.rvalid, 1'b1);
            check("stall_rdata", s_axi.rdata, e.data);
            check("stall_rlast", s_axi.rlast, e.last);
            check("stall_rid", s_axi.rid, e.id);
            tick();
          end
          s_axi.rready = 1'b1;
        end
      end else begin
        tick();
      end
      t++;
    end
    if (!done) note_fail("r_burst_end");
    s_axi.rready = 1'b0;
  endtask

  initial begin
    int t;
    n_checks = 0; n_fail = 0; grant_log = "";
    reset = 1'b1;
    s_axi.awid = 4'd0; s_axi.awaddr = 32'd0; s_axi.awlen = 8'd0; s_axi.awsize = 3'd0;
    s_axi.awburst = 2'b00; s_axi.awlock = 1'b0; s_axi.awcache = 4'd0; s_axi.awprot = 3'd0;
    s_axi.awqos = 4'd0; s_axi.awvalid = 1'b0;
    s_axi.wdata = 64'd0; s_axi.wstrb = 8'd0; s_axi.wlast = 1'b0; s_axi.wvalid = 1'b0;
    s_axi.bready = 1'b1;
    s_axi.arid = 4'd0; s_axi.araddr = 32'd0; s_axi.arlen = 8'd0; s_axi.arsize = 3'd0;
    s_axi.arburst = 2'b00; s_axi.arlock = 1'b0; s_axi.arcache = 4'd0; s_axi.arprot = 3'd0;
    s_axi.arqos = 4'd0; s_axi.arvalid = 1'b0;
    s_axi.rready = 1'b0;
    repeat (3) tick();

    check("rst_awready", s_axi.awready, 1'b0);
    check("rst_arready", s_axi.arready, 1'b0);
    check("rst_wready", s_axi.wready, 1'b0);
    check("rst_bvalid", s_axi.bvalid, 1'b0);
    check("rst_rvalid", s_axi.rvalid, 1'b0);
    check("rst_rdata", s_axi.rdata, 64'd0);
    check("rst_rlast", s_axi.rlast, 1'b0);
    reset = 1'b0;
    tick();

    // Simultaneous AW+AR: write wins first; the AW arriving while AR waits loses next.
    tb_wd[0] = 64'hA1A1_A1A1_A1A1_A1A1;
    push_r(4'h2, 64'hA1A1_A1A1_A1A1_A1A1, 2'b00, 1'b1);
    grant_log = "";
    fork
      begin
        write_burst(4'h1, 32'h8000_0100, 8'd0, 3'd3, 2'b01, 8'hFF, 1, 2'b00, 0);
        tb_wd[0] = 64'hB2B2_B2B2_B2B2_B2B2;
        write_burst(4'h3, 32'h8000_0108, 8'd0, 3'd3, 2'b01, 8'hFF, 1, 2'b00, 0);
      end
      begin
        read_burst(4'h2, 32'h8000_0100, 8'd0, 3'd3, 2'b01, 0);
      end
    join
    n_checks++;
    if (grant_log != "WRW") begin
      n_fail++;
      $display("FAIL grant_order: got %s expected WRW", grant_log);
    end

    // INCR write then read back.
    tb_wd[0] = 64'h11; tb_wd[1] = 64'h22; tb_wd[2] = 64'h33; tb_wd[3] = 64'h44;
    write_burst(4'h5, 32'h8000_0010, 8'd3, 3'd3, 2'b01, 8'hFF, 4, 2'b00, 0);
    push_r(4'h6, 64'h11, 2'b00, 1'b0);
    push_r(4'h6, 64'h22, 2'b00, 1'b0);
    push_r(4'h6, 64'h33, 2'b00, 1'b0);
    push_r(4'h6, 64'h44, 2'b00, 1'b1);
    read_burst(4'h6, 32'h8000_0010, 8'd3, 3'd3, 2'b01, 0);

    // WRAP write of the lower halves over an all-ones block.
    for (int k = 0; k < 4; k++) tb_wd[k] = 64'hFFFF_FFFF_FFFF_FFFF;
    write_burst(4'h7, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 8'hFF, 4, 2'b00, 0);
    tb_wd[0] = 64'h5555_5555_AAAA_0018; tb_wd[1] = 64'h5555_5555_AAAA_0000;
    tb_wd[2] = 64'h5555_5555_AAAA_0008; tb_wd[3] = 64'h5555_5555_AAAA_0010;
    write_burst(4'h8, 32'h8000_0018, 8'd3, 3'd3, 2'b10, 8'h0F, 4, 2'b00, 0);
    push_r(4'h9, 64'hFFFF_FFFF_AAAA_0000, 2'b00, 1'b0);
    push_r(4'h9, 64'hFFFF_FFFF_AAAA_0008, 2'b00, 1'b0);
    push_r(4'h9, 64'hFFFF_FFFF_AAAA_0010, 2'b00, 1'b0);
    push_r(4'h9, 64'hFFFF_FFFF_AAAA_0018, 2'b00, 1'b1);
    read_burst(4'h9, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 0);

    // Just past the window: DECERR, zero data, and word 0 must not be aliased.
    push_r(4'hA, 64'd0, 2'b11, 1'b0);
    push_r(4'hA, 64'd0, 2'b11, 1'b1);
    read_burst(4'hA, 32'h8000_1000, 8'd1, 3'd3, 2'b01, 0);
    tb_wd[0] = 64'h0;
    write_burst(4'hB, 32'h8000_1000, 8'd0, 3'd3, 2'b01, 8'hFF, 1, 2'b11, 0);
    push_r(4'hC, 64'hFFFF_FFFF_AAAA_0000, 2'b00, 1'b1);
    read_burst(4'hC, 32'h8000_0000, 8'd0, 3'd3, 2'b01, 0);

    // Reserved burst type and illegal WRAP length.
    push_r(4'hD, 64'hFFFF_FFFF_AAAA_0000, 2'b10, 1'b1);
    read_burst(4'hD, 32'h8000_0000, 8'd0, 3'd3, 2'b11, 0);
    tb_wd[0] = 64'h1; tb_wd[1] = 64'h2; tb_wd[2] = 64'h3;
    write_burst(4'hD, 32'h8000_0040, 8'd2, 3'd3, 2'b10, 8'hFF, 3, 2'b10, 0);

    // Backpressure on R and B, then an early wlast.
    push_r(4'h4, 64'hFFFF_FFFF_AAAA_0000, 2'b00, 1'b0);
    push_r(4'h4, 64'hFFFF_FFFF_AAAA_0008, 2'b00, 1'b0);
    push_r(4'h4, 64'hFFFF_FFFF_AAAA_0010, 2'b00, 1'b0);
    push_r(4'h4, 64'hFFFF_FFFF_AAAA_0018, 2'b00, 1'b1);
    read_burst(4'h4, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 2);
    tb_wd[0] = 64'h77;
    write_burst(4'h3, 32'h8000_0200, 8'd0, 3'd3, 2'b01, 8'hFF, 1, 2'b00, 3);
    tb_wd[0] = 64'h88; tb_wd[1] = 64'h99;
    write_burst(4'h2, 32'h8000_0300, 8'd3, 3'd3, 2'b01, 8'hFF, 2, 2'b10, 0);

    // Reset pulsed while beat 2 of a read is presented.
    push_r(4'hE, 64'h33, 2'b00, 1'b0);
    do_ar(4'hE, 32'h8000_0020, 8'd3, 3'd3, 2'b01);
    s_axi.rready = 1'b1;
    t = 0;
    while (!(s_axi.rvalid && s_axi.rready) && t < 30) begin tick(); t++; end
    if (!s_axi.rvalid) note_fail("r6_first_beat");
    tick();
    s_axi.rready = 1'b0;
    t = 0;
    while (!s_axi.rvalid && t < 30) begin tick(); t++; end
    check("pre_reset_rvalid", s_axi.rvalid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("post_reset_rvalid", s_axi.rvalid, 1'b0);
    check("post_reset_bvalid", s_axi.bvalid, 1'b0);
    push_r(4'hF, 64'h33, 2'b00, 1'b0);
    push_r(4'hF, 64'h44, 2'b00, 1'b1);
    read_burst(4'hF, 32'h8000_0020, 8'd1, 3'd3, 2'b01, 0);

    repeat (3) tick();
    check("b_queue_drained", exp_b.size(), 64'd0);
    check("r_queue_drained", exp_r.size(), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
